// File: rtl/infix_to_postfix.sv
// Shunting-yard infix-to-postfix converter with an internal operator stack.
// The stack operation of each cycle is exposed on the debug ports for the evaluator.
module infix_to_postfix #(
   parameter int unsigned LENGTH = 11,
   parameter int unsigned WIDTH  = 8
) (
   input  logic                                 CLK,
   input  logic                                 RST,
   input  logic                                 start,
   input  logic [1:0][LENGTH-1:0][WIDTH-1:0]    infix,
   output logic [1:0][LENGTH-1:0][WIDTH-1:0]    postfix,
   output logic                                 busy,
   output logic                                 done,
   output logic                                 error,
   output logic [WIDTH-1:0]                     token,
   output logic [WIDTH-1:0]                     top,
   output logic [2:0]                           opcode,
   output logic [WIDTH-1:0]                     input_data,
   output logic [WIDTH-1:0]                     output_data
);

   localparam int unsigned IW = $clog2(LENGTH + 1);

   localparam logic [WIDTH-1:0] FLAG_OPND = WIDTH'(0);
   localparam logic [WIDTH-1:0] FLAG_OPR  = WIDTH'(1);
   localparam logic [WIDTH-1:0] FLAG_END  = '1;

   localparam logic [WIDTH-1:0] CH_LP  = WIDTH'(40);
   localparam logic [WIDTH-1:0] CH_RP  = WIDTH'(41);
   localparam logic [WIDTH-1:0] CH_MUL = WIDTH'(42);
   localparam logic [WIDTH-1:0] CH_ADD = WIDTH'(43);
   localparam logic [WIDTH-1:0] CH_SUB = WIDTH'(45);
   localparam logic [WIDTH-1:0] CH_DIV = WIDTH'(47);

   localparam logic [2:0] OP_NOP   = 3'd0;
   localparam logic [2:0] OP_PUSH  = 3'd1;
   localparam logic [2:0] OP_POP   = 3'd2;
   localparam logic [2:0] OP_CLEAR = 3'd3;

   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SCAN, S_FLUSH, S_DONE} state_t;

   state_t                             r_state, w_state_nxt;
   logic [1:0][LENGTH-1:0][WIDTH-1:0]  r_in;
   logic [1:0][LENGTH-1:0][WIDTH-1:0]  r_post;
   logic [LENGTH-1:0][WIDTH-1:0]       r_stack;
   logic [IW-1:0]                      r_sp;
   logic [IW-1:0]                      r_in_idx;
   logic [IW-1:0]                      r_out_idx;
   logic                               r_err;
   logic                               r_busy;
   logic                               r_done;
   logic                               r_error;
   logic [WIDTH-1:0]                   r_token;
   logic [WIDTH-1:0]                   r_top;
   logic [2:0]                         r_opcode;
   logic [WIDTH-1:0]                   r_input_data;
   logic [WIDTH-1:0]                   r_output_data;

   logic                               w_empty;
   logic [WIDTH-1:0]                   w_top_val;
   logic [WIDTH-1:0]                   w_cur_val;
   logic [WIDTH-1:0]                   w_cur_flag;
   logic [2:0]                         w_op;
   logic [WIDTH-1:0]                   w_push_val;
   logic                               w_emit;
   logic [WIDTH-1:0]                   w_emit_val;
   logic [WIDTH-1:0]                   w_emit_flag;
   logic                               w_in_inc;
   logic                               w_err_set;
   logic                               w_load;
   logic                               w_finish;
   logic [IW-1:0]                      w_idx_nxt;

   function automatic logic [1:0] prec(input logic [WIDTH-1:0] v);
      case (v)
         CH_MUL, CH_DIV: prec = 2'd2;
         CH_ADD, CH_SUB: prec = 2'd1;
         default:        prec = 2'd0;
      endcase
   endfunction

   assign w_empty    = (r_sp == IW'(0));
   assign w_top_val  = w_empty ? '0 : r_stack[r_sp - IW'(1)];
   assign w_cur_val  = (r_in_idx < IW'(LENGTH)) ? r_in[0][r_in_idx] : '0;
   assign w_cur_flag = (r_in_idx < IW'(LENGTH)) ? r_in[1][r_in_idx] : FLAG_END;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next state and one conversion action per cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_op        = OP_NOP;
      w_push_val  = '0;
      w_emit      = 1'b0;
      w_emit_val  = '0;
      w_emit_flag = FLAG_OPND;
      w_in_inc    = 1'b0;
      w_err_set   = 1'b0;
      w_load      = 1'b0;
      w_finish    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_load      = 1'b1;
               w_state_nxt = S_CLEAR;
            end
         end
         S_CLEAR: begin
            w_op        = OP_CLEAR;
            w_state_nxt = S_SCAN;
         end
         S_SCAN: begin
            if (r_in_idx == IW'(LENGTH) || w_cur_flag == FLAG_END) begin
               w_state_nxt = S_FLUSH;
            end else if (w_cur_flag == FLAG_OPND) begin
               w_emit     = 1'b1;
               w_emit_val = w_cur_val;
               w_in_inc   = 1'b1;
            end else if (w_cur_flag == FLAG_OPR) begin
               case (w_cur_val)
                  CH_LP: begin
                     w_op       = OP_PUSH;
                     w_push_val = w_cur_val;
                     w_in_inc   = 1'b1;
                  end
                  CH_RP: begin
                     if (w_empty) begin
                        w_err_set = 1'b1;
                        w_in_inc  = 1'b1;
                     end else if (w_top_val == CH_LP) begin
                        w_op     = OP_POP;
                        w_in_inc = 1'b1;
                     end else begin
                        w_op        = OP_POP;
                        w_emit      = 1'b1;
                        w_emit_val  = w_top_val;
                        w_emit_flag = FLAG_OPR;
                     end
                  end
                  CH_ADD, CH_SUB, CH_MUL, CH_DIV: begin
                     if (!w_empty && w_top_val != CH_LP && prec(w_top_val) >= prec(w_cur_val)) begin
                        w_op        = OP_POP;
                        w_emit      = 1'b1;
                        w_emit_val  = w_top_val;
                        w_emit_flag = FLAG_OPR;
                     end else begin
                        w_op       = OP_PUSH;
                        w_push_val = w_cur_val;
                        w_in_inc   = 1'b1;
                     end
                  end
                  default: begin
                     w_err_set = 1'b1;
                     w_in_inc  = 1'b1;
                  end
               endcase
            end else begin
               w_err_set = 1'b1;
               w_in_inc  = 1'b1;
            end
         end
         S_FLUSH: begin
            if (w_empty) begin
               w_finish    = 1'b1;
               w_state_nxt = S_DONE;
            end else begin
               w_op = OP_POP;
               if (w_top_val == CH_LP) begin
                  w_err_set = 1'b1;
               end else begin
                  w_emit      = 1'b1;
                  w_emit_val  = w_top_val;
                  w_emit_flag = FLAG_OPR;
               end
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_idx_nxt = w_load ? IW'(0) : (w_in_inc ? r_in_idx + IW'(1) : r_in_idx);

   // Datapath: input latch, output array, operator stack and debug registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_in          <= '0;
         r_post[0]     <= '0;
         r_post[1]     <= '1;
         r_stack       <= '0;
         r_sp          <= '0;
         r_in_idx      <= '0;
         r_out_idx     <= '0;
         r_err         <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_error       <= 1'b0;
         r_token       <= '0;
         r_top         <= '0;
         r_opcode      <= OP_NOP;
         r_input_data  <= '0;
         r_output_data <= '0;
      end else begin
         r_opcode <= w_op;
         r_done   <= w_finish;
         if (w_load) begin
            r_in      <= infix;
            r_post[0] <= '0;
            r_post[1] <= '1;
            r_in_idx  <= '0;
            r_out_idx <= '0;
            r_err     <= 1'b0;
            r_error   <= 1'b0;
            r_busy    <= 1'b1;
         end
         if (w_emit && r_out_idx < IW'(LENGTH)) begin
            r_post[0][r_out_idx] <= w_emit_val;
            r_post[1][r_out_idx] <= w_emit_flag;
            r_out_idx            <= r_out_idx + IW'(1);
         end
         if (w_in_inc)  r_in_idx <= r_in_idx + IW'(1);
         if (w_err_set) r_err    <= 1'b1;
         if (w_finish) begin
            r_busy  <= 1'b0;
            r_error <= r_err;
         end
         if (w_state_nxt == S_SCAN)
            r_token <= (w_idx_nxt < IW'(LENGTH)) ? r_in[0][w_idx_nxt] : '0;
         case (w_op)
            OP_CLEAR: begin
               r_sp  <= '0;
               r_top <= '0;
            end
            OP_PUSH: begin
               if (r_sp < IW'(LENGTH)) begin
                  r_stack[r_sp] <= w_push_val;
                  r_sp          <= r_sp + IW'(1);
                  r_top         <= w_push_val;
               end
               r_input_data <= w_push_val;
            end
            OP_POP: begin
               r_sp          <= r_sp - IW'(1);
               r_output_data <= w_top_val;
               r_top         <= (r_sp > IW'(1)) ? r_stack[r_sp - IW'(2)] : '0;
            end
            default: ;
         endcase
      end
   end

   assign postfix     = r_post;
   assign busy        = r_busy;
   assign done        = r_done;
   assign error       = r_error;
   assign token       = r_token;
   assign top         = r_top;
   assign opcode      = r_opcode;
   assign input_data  = r_input_data;
   assign output_data = r_output_data;

endmodule

// File: tb/tb_infix_to_postfix.sv
// Directed self-checking bench for infix_to_postfix: precedence, associativity,
// parenthesis errors, mid-conversion reset and start-while-busy.
module tb_infix_to_postfix;

   localparam int unsigned LENGTH = 11;
   localparam int unsigned WIDTH  = 8;
   localparam int unsigned AW     = 2 * LENGTH * WIDTH;

   typedef logic [1:0][LENGTH-1:0][WIDTH-1:0] arr_t;

   logic             CLK;
   logic             RST;
   logic             start;
   arr_t             infix;
   arr_t             postfix;
   logic             busy;
   logic             done;
   logic             error;
   logic [WIDTH-1:0] token;
   logic [WIDTH-1:0] top;
   logic [2:0]       opcode;
   logic [WIDTH-1:0] input_data;
   logic [WIDTH-1:0] output_data;

   int tests;
   int fails;
   int v[LENGTH];
   int f[LENGTH];
   int n_done;
   logic busy_fell;
   logic pop45_seen;
   int push45_cnt;
   int push45_at_pop;
   arr_t pad;
   arr_t exp_main;

   infix_to_postfix #(.LENGTH(LENGTH), .WIDTH(WIDTH)) dut (
      .CLK(CLK), .RST(RST), .start(start), .infix(infix), .postfix(postfix),
      .busy(busy), .done(done), .error(error), .token(token), .top(top),
      .opcode(opcode), .input_data(input_data), .output_data(output_data)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic arr_t pack(input int vv[LENGTH], input int ff[LENGTH]);
      arr_t r;
      for (int i = 0; i < LENGTH; i++) begin
         r[0][i] = WIDTH'(vv[i]);
         r[1][i] = WIDTH'(ff[i]);
      end
      return r;
   endfunction

   task automatic check(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp_v);
      tests++;
      assert (obs === exp_v) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic pulse_start;
      start = 1'b1;
      @(posedge CLK);
      #1;
      start = 1'b0;
   endtask

   // Waits for done (bounded), counts pulses, tracks busy and '-' stack traffic.
   task automatic wait_done(input int budget);
      logic prev_busy;
      int   extra;
      n_done        = 0;
      busy_fell     = 1'b0;
      pop45_seen    = 1'b0;
      push45_cnt    = 0;
      push45_at_pop = -1;
      prev_busy     = busy;
      extra         = 0;
      for (int c = 0; c < budget; c++) begin
         @(posedge CLK);
         #1;
         if (opcode == 3'd2 && output_data == 8'd45 && !pop45_seen) begin
            pop45_seen    = 1'b1;
            push45_at_pop = push45_cnt;
         end
         if (opcode == 3'd1 && input_data == 8'd45) push45_cnt++;
         if (done) begin
            n_done++;
            if (prev_busy && !busy) busy_fell = 1'b1;
         end
         prev_busy = busy;
         if (n_done > 0) extra++;
         if (extra > 3) break;
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      RST   = 1'b1;
      start = 1'b0;
      for (int i = 0; i < LENGTH; i++) begin
         v[i] = 0;
         f[i] = 255;
      end
      pad   = pack(v, f);
      infix = pad;

      #12;
      check("rst_postfix", AW'(postfix), AW'(pad));
      check("rst_busy",    AW'(busy),    AW'(0));
      check("rst_done",    AW'(done),    AW'(0));
      check("rst_error",   AW'(error),   AW'(0));
      check("rst_top",     AW'(top),     AW'(0));
      check("rst_opcode",  AW'(opcode),  AW'(0));
      check("rst_token",   AW'(token),   AW'(0));
      @(posedge CLK);
      #1;
      RST = 1'b0;
      tick(2);

      // 5*(4-2+1)-6
      v = '{5, 42, 40, 4, 45, 2, 43, 1, 41, 45, 6};
      f = '{0, 1, 1, 0, 1, 0, 1, 0, 1, 1, 0};
      infix = pack(v, f);
      v = '{5, 4, 2, 45, 1, 43, 42, 6, 45, 0, 0};
      f = '{0, 0, 0, 1, 0, 1, 1, 0, 1, 255, 255};
      exp_main = pack(v, f);
      pulse_start;
      check("main_busy_after_start", AW'(busy), AW'(1));
      wait_done(100);
      check("main_postfix",   AW'(postfix),   AW'(exp_main));
      check("main_error",     AW'(error),     AW'(0));
      check("main_done_cnt",  AW'(n_done),    AW'(1));
      check("main_busy_fell", AW'(busy_fell), AW'(1));

      // 2+3*4
      v = '{2, 43, 3, 42, 4, 0, 0, 0, 0, 0, 0};
      f = '{0, 1, 0, 1, 0, 255, 255, 255, 255, 255, 255};
      infix = pack(v, f);
      v = '{2, 3, 4, 42, 43, 0, 0, 0, 0, 0, 0};
      f = '{0, 0, 0, 1, 1, 255, 255, 255, 255, 255, 255};
      pulse_start;
      wait_done(100);
      check("prec_postfix",   AW'(postfix),   AW'(pack(v, f)));
      check("prec_error",     AW'(error),     AW'(0));
      check("prec_busy_fell", AW'(busy_fell), AW'(1));

      // 8-3-1
      v = '{8, 45, 3, 45, 1, 0, 0, 0, 0, 0, 0};
      f = '{0, 1, 0, 1, 0, 255, 255, 255, 255, 255, 255};
      infix = pack(v, f);
      v = '{8, 3, 45, 1, 45, 0, 0, 0, 0, 0, 0};
      f = '{0, 0, 1, 0, 1, 255, 255, 255, 255, 255, 255};
      pulse_start;
      wait_done(100);
      check("assoc_postfix",     AW'(postfix),       AW'(pack(v, f)));
      check("assoc_pop_seen",    AW'(pop45_seen),    AW'(1));
      check("assoc_pop_order",   AW'(push45_at_pop), AW'(1));
      check("assoc_total_push",  AW'(push45_cnt),    AW'(2));

      // (1+2
      v = '{40, 1, 43, 2, 0, 0, 0, 0, 0, 0, 0};
      f = '{1, 0, 1, 0, 255, 255, 255, 255, 255, 255, 255};
      infix = pack(v, f);
      v = '{1, 2, 43, 0, 0, 0, 0, 0, 0, 0, 0};
      f = '{0, 0, 1, 255, 255, 255, 255, 255, 255, 255, 255};
      pulse_start;
      wait_done(100);
      check("lparen_postfix", AW'(postfix), AW'(pack(v, f)));
      check("lparen_error",   AW'(error),   AW'(1));
      check("lparen_done",    AW'(n_done),  AW'(1));

      // 1)+2
      v = '{1, 41, 43, 2, 0, 0, 0, 0, 0, 0, 0};
      f = '{0, 1, 1, 0, 255, 255, 255, 255, 255, 255, 255};
      infix = pack(v, f);
      v = '{1, 2, 43, 0, 0, 0, 0, 0, 0, 0, 0};
      f = '{0, 0, 1, 255, 255, 255, 255, 255, 255, 255, 255};
      pulse_start;
      wait_done(100);
      check("rparen_postfix", AW'(postfix), AW'(pack(v, f)));
      check("rparen_error",   AW'(error),   AW'(1));

      // Reset in the middle of the main expression
      v = '{5, 42, 40, 4, 45, 2, 43, 1, 41, 45, 6};
      f = '{0, 1, 1, 0, 1, 0, 1, 0, 1, 1, 0};
      infix = pack(v, f);
      pulse_start;
      tick(3);
      check("mid_top",   AW'(top),        AW'(42));
      check("mid_push",  AW'(input_data), AW'(42));
      check("mid_token", AW'(token),      AW'(40));
      check("mid_error_cleared", AW'(error), AW'(0));
      RST = 1'b1;
      #1;
      check("arst_postfix", AW'(postfix),     AW'(pad));
      check("arst_busy",    AW'(busy),        AW'(0));
      check("arst_top",     AW'(top),         AW'(0));
      check("arst_opcode",  AW'(opcode),      AW'(0));
      check("arst_indata",  AW'(input_data),  AW'(0));
      check("arst_outdata", AW'(output_data), AW'(0));
      check("arst_token",   AW'(token),       AW'(0));
      @(posedge CLK);
      #1;
      RST = 1'b0;
      wait_done(30);
      check("arst_no_done", AW'(n_done), AW'(0));

      pulse_start;
      wait_done(100);
      check("after_rst_postfix", AW'(postfix), AW'(exp_main));
      check("after_rst_done",    AW'(n_done),  AW'(1));

      // Start while busy must be ignored
      pulse_start;
      tick(3);
      v = '{2, 43, 3, 42, 4, 0, 0, 0, 0, 0, 0};
      f = '{0, 1, 0, 1, 0, 255, 255, 255, 255, 255, 255};
      infix = pack(v, f);
      pulse_start;
      wait_done(100);
      check("busy_start_postfix", AW'(postfix), AW'(exp_main));
      check("busy_start_done",    AW'(n_done),  AW'(1));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
